// File: rtl/writeback_regfile_if.sv
// MEM/WB-to-regfile bus: write-back controls and data in, decode read ports and
// commit status out.
interface writeback_regfile_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              mem_to_reg;
  logic              reg_write;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] mem_data;
  logic [ADDR_W-1:0] write_reg;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] wb_data;
  logic              wb_valid;
  logic [31:0]       commit_count;

  modport master (
    output mem_to_reg, reg_write, alu_result, mem_data, write_reg, rs_addr, rt_addr,
    input  rs_data, rt_data, wb_data, wb_valid, commit_count
  );

  modport slave (
    input  mem_to_reg, reg_write, alu_result, mem_data, write_reg, rs_addr, rt_addr,
    output rs_data, rt_data, wb_data, wb_valid, commit_count
  );
endinterface

// File: rtl/writeback_regfile.sv
// Write-back select plus 2**ADDR_W x DATA_W register file with two bypassed read ports.
// Register 0 reads as zero and is never written.
module writeback_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input logic                clk,
  input logic                rst_n,
  writeback_regfile_if.slave bus
);
  localparam int unsigned NumRegs = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NumRegs];
  logic [31:0]       commit_q;
  logic [DATA_W-1:0] wb_data;
  logic              wb_valid;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;

  always_comb begin
    wb_data  = bus.mem_to_reg ? bus.mem_data : bus.alu_result;
    wb_valid = bus.reg_write && (bus.write_reg != '0);
  end

  // Reset also masks the bypass so ID sees all zeros while rst_n is low.
  always_comb begin
    rs_data = '0;
    if (rst_n && (bus.rs_addr != '0)) begin
      if (wb_valid && (bus.rs_addr == bus.write_reg)) begin
        rs_data = wb_data;
      end else begin
        rs_data = regs_q[bus.rs_addr];
      end
    end
  end

  always_comb begin
    rt_data = '0;
    if (rst_n && (bus.rt_addr != '0)) begin
      if (wb_valid && (bus.rt_addr == bus.write_reg)) begin
        rt_data = wb_data;
      end else begin
        rt_data = regs_q[bus.rt_addr];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NumRegs); i++) begin
        regs_q[i] <= '0;
      end
      commit_q <= '0;
    end else if (wb_valid) begin
      regs_q[bus.write_reg] <= wb_data;
      commit_q              <= commit_q + 32'd1;
    end
  end

  assign bus.wb_data      = wb_data;
  assign bus.wb_valid     = wb_valid;
  assign bus.rs_data      = rs_data;
  assign bus.rt_data      = rt_data;
  assign bus.commit_count = commit_q;
endmodule

// File: tb/tb_writeback_regfile.sv
// Randomized self-checking bench for writeback_regfile against an array-based model.
module tb_writeback_regfile;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  writeback_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  writeback_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] model_regs [32];
  logic [31:0] model_count;

  function automatic logic [31:0] model_wb();
    return bus.mem_to_reg ? bus.mem_data : bus.alu_result;
  endfunction

  function automatic logic model_valid();
    return bus.reg_write && (bus.write_reg != 5'd0);
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (!rst_n || a == 5'd0) return 32'd0;
    if (model_valid() && a == bus.write_reg) return model_wb();
    return model_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    model_count = 32'd0;
  endtask

  // Advance one rising edge and apply the architectural effect to the model.
  task automatic clock_edge();
    logic v;
    logic [31:0] d;
    logic [4:0] w;
    v = model_valid();
    d = model_wb();
    w = bus.write_reg;
    @(posedge clk);
    if (rst_n && v) begin
      model_regs[w] = d;
      model_count   = model_count + 32'd1;
    end
    #1;
  endtask

  task automatic drive(input logic rw, input logic m2r, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [4:0] wr);
    bus.reg_write  = rw;
    bus.mem_to_reg = m2r;
    bus.alu_result = alu;
    bus.mem_data   = mem;
    bus.write_reg  = wr;
  endtask

  task automatic test_reset();
    model_reset();
    drive(1'b1, 1'b0, 32'h0BAD_F00D, 32'h1357_9BDF, 5'd9);
    bus.rs_addr = 5'd9;
    bus.rt_addr = 5'd1;
    #2;
    checks++;
    if (bus.commit_count !== 32'd0) begin
      errors++; $display("FAIL reset_count got=%h exp=0", bus.commit_count);
    end
    checks++;
    if (bus.rs_data !== 32'd0 || bus.rt_data !== 32'd0) begin
      errors++; $display("FAIL reset_read got=%h/%h exp=0", bus.rs_data, bus.rt_data);
    end
    checks++;
    if (bus.wb_data !== 32'h0BAD_F00D || bus.wb_valid !== 1'b1) begin
      errors++; $display("FAIL reset_wb got=%h/%b exp=0badf00d/1", bus.wb_data, bus.wb_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Mid-run reset: commit regs[5], then assert reset with a write pending.
    drive(1'b1, 1'b0, 32'h0000_1234, 32'h0, 5'd5);
    clock_edge();
    bus.reg_write = 1'b0;
    bus.rs_addr   = 5'd5;
    #1;
    checks++;
    if (bus.rs_data !== 32'h0000_1234) begin
      errors++; $display("FAIL pre_reset_read got=%h exp=00001234", bus.rs_data);
    end
    drive(1'b1, 1'b0, 32'h5555_AAAA, 32'h0, 5'd6);
    bus.rt_addr = 5'd6;
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.rs_data !== 32'd0 || bus.rt_data !== 32'd0 || bus.commit_count !== 32'd0) begin
      errors++;
      $display("FAIL midrun_reset got=%h/%h cnt=%h exp=0", bus.rs_data, bus.rt_data,
               bus.commit_count);
    end
    clock_edge();
    @(negedge clk);
    rst_n = 1'b1;
    bus.reg_write = 1'b0;
    #1;
    checks++;
    if (bus.rs_data !== 32'd0 || bus.rt_data !== 32'd0) begin
      errors++; $display("FAIL post_reset_read got=%h/%h exp=0", bus.rs_data, bus.rt_data);
    end
  endtask

  task automatic test_basic_write();
    drive(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h1111_1111, 5'd7);
    bus.rs_addr = 5'd7;
    #1;
    checks++;
    if (bus.wb_data !== 32'hDEAD_BEEF || bus.wb_valid !== 1'b1) begin
      errors++; $display("FAIL select_alu got=%h/%b exp=deadbeef/1", bus.wb_data, bus.wb_valid);
    end
    clock_edge();
    bus.reg_write = 1'b0;
    #1;
    checks++;
    if (bus.rs_data !== 32'hDEAD_BEEF || bus.commit_count !== 32'd1) begin
      errors++;
      $display("FAIL write_alu got=%h cnt=%0d exp=deadbeef cnt=1", bus.rs_data,
               bus.commit_count);
    end
    drive(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1111_1111, 5'd8);
    #1;
    checks++;
    if (bus.wb_data !== 32'h1111_1111) begin
      errors++; $display("FAIL select_mem got=%h exp=11111111", bus.wb_data);
    end
    clock_edge();
    bus.reg_write = 1'b0;
    bus.rt_addr   = 5'd8;
    #1;
    checks++;
    if (bus.rt_data !== 32'h1111_1111 || bus.commit_count !== 32'd2) begin
      errors++;
      $display("FAIL write_mem got=%h cnt=%0d exp=11111111 cnt=2", bus.rt_data,
               bus.commit_count);
    end
  endtask

  task automatic test_bypass();
    drive(1'b1, 1'b0, 32'hA, 32'h0, 5'd3);
    clock_edge();
    drive(1'b1, 1'b0, 32'hB, 32'h0, 5'd3);
    bus.rs_addr = 5'd3;
    bus.rt_addr = 5'd3;
    #1;
    checks++;
    if (bus.rs_data !== 32'hB || bus.rt_data !== 32'hB) begin
      errors++; $display("FAIL bypass_on got=%h/%h exp=b", bus.rs_data, bus.rt_data);
    end
    bus.reg_write = 1'b0;
    #1;
    checks++;
    if (bus.rs_data !== 32'hA || bus.rt_data !== 32'hA) begin
      errors++; $display("FAIL bypass_off got=%h/%h exp=a", bus.rs_data, bus.rt_data);
    end
  endtask

  task automatic test_reg_zero();
    logic [31:0] cnt;
    cnt = bus.commit_count;
    drive(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 5'd0);
    bus.rs_addr = 5'd0;
    #1;
    checks++;
    if (bus.wb_valid !== 1'b0 || bus.rs_data !== 32'd0 || bus.wb_data !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL zero_pre got=%b/%h/%h exp=0/0/ffffffff", bus.wb_valid, bus.rs_data,
               bus.wb_data);
    end
    clock_edge();
    checks++;
    if (bus.rs_data !== 32'd0 || bus.commit_count !== model_count) begin
      errors++;
      $display("FAIL zero_post got=%h cnt=%h exp=0 cnt=%h (before %h)", bus.rs_data,
               bus.commit_count, model_count, cnt);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    bus.rt_addr = 5'd31;
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 1'b0, i * 32'h0101_0101, 32'hFFFF_0000, i[4:0]);
      if (i == 31) begin
        #1;
        checks++;
        if (bus.rt_data !== 32'h1F1F_1F1F) begin
          errors++; $display("FAIL b2b_bypass got=%h exp=1f1f1f1f", bus.rt_data);
        end
      end
      clock_edge();
    end
    bus.reg_write = 1'b0;
    for (int i = 1; i < 32; i++) begin
      bus.rs_addr = i[4:0];
      bus.rt_addr = 5'(32 - i);
      #1;
      checks++;
      if (bus.rs_data !== i * 32'h0101_0101 ||
          bus.rt_data !== (32 - i) * 32'h0101_0101) begin
        errors++;
        $display("FAIL b2b_read idx=%0d got=%h/%h exp=%h/%h", i, bus.rs_data, bus.rt_data,
                 i * 32'h0101_0101, (32 - i) * 32'h0101_0101);
      end
    end
    checks++;
    if (bus.commit_count !== 32'd31) begin
      errors++; $display("FAIL b2b_count got=%0d exp=31", bus.commit_count);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, $urandom, $urandom,
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom));
      bus.rs_addr = ($urandom_range(0, 3) == 0) ? bus.write_reg : 5'($urandom);
      bus.rt_addr = ($urandom_range(0, 3) == 0) ? bus.write_reg : 5'($urandom);
      #1;
      checks++;
      if (bus.wb_data !== model_wb() || bus.wb_valid !== model_valid() ||
          bus.rs_data !== model_read(bus.rs_addr) || bus.rt_data !== model_read(bus.rt_addr) ||
          bus.commit_count !== model_count) begin
        errors++;
        $display("FAIL random n=%0d got=%h/%b/%h/%h/%h exp=%h/%b/%h/%h/%h", n, bus.wb_data,
                 bus.wb_valid, bus.rs_data, bus.rt_data, bus.commit_count, model_wb(),
                 model_valid(), model_read(bus.rs_addr), model_read(bus.rt_addr), model_count);
      end
      clock_edge();
    end
  endtask

  task automatic test_counter_wrap();
    bus.reg_write = 1'b0;
    force dut.commit_q = 32'hFFFF_FFFF;
    #1;
    release dut.commit_q;
    model_count = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (bus.commit_count !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL wrap_preload got=%h exp=ffffffff", bus.commit_count);
    end
    drive(1'b1, 1'b0, 32'h0000_0044, 32'h0, 5'd4);
    clock_edge();
    checks++;
    if (bus.commit_count !== 32'd0 || bus.commit_count !== model_count) begin
      errors++; $display("FAIL wrap got=%h exp=0", bus.commit_count);
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    bus.rs_addr = 5'd0;
    bus.rt_addr = 5'd0;
    test_reset();
    test_basic_write();
    test_bypass();
    test_reg_zero();
    test_back_to_back();
    test_random();
    test_counter_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
